// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter that shares a single fifo_8bit write port
//            among NUM_REQ producers. A producer keeps ownership for a burst
//            of up to MAX_BURST accepted beats. Ownership also ends when the
//            producer withdraws its request. The fifo full flag stalls the
//            current owner without ending its burst.
// Ports    : clk          - system clock, rising edge
//            rst          - synchronous active-high reset
//            req          - per-producer write request (bit i = producer i)
//            req_data     - producer data, slice i = [i*DATA_W +: DATA_W]
//            ack          - one-hot per-beat accept (data written this cycle)
//            grant        - registered one-hot owner, zero when idle
//            fifo_full    - full flag from the fifo
//            fifo_wr      - write strobe to the fifo
//            fifo_data_in - write data to the fifo
//            busy         - high while a producer holds the grant
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      busy
);

    localparam int         c_IDX_W     = $clog2(NUM_REQ);
    localparam logic [7:0] c_LAST_BEAT = 8'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [c_IDX_W-1:0]   r_g_idx;
    logic [c_IDX_W-1:0]   r_last_idx;
    logic [7:0]           r_beat_cnt;

    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [c_IDX_W-1:0]   w_g_idx_nxt;
    logic [c_IDX_W-1:0]   w_last_idx_nxt;
    logic [7:0]           w_beat_cnt_nxt;

    logic                 w_own_req;
    logic [DATA_W-1:0]    w_own_data;
    logic                 w_sel_found;
    logic [c_IDX_W-1:0]   w_sel_idx;
    logic                 w_beat;

    // ------------------------------------------------------------------
    // Owner request/data mux, decoded from the registered index so that
    // the fifo sees data that depends only on stable state plus req.
    // ------------------------------------------------------------------
    always_comb begin : p_owner_mux
        w_own_req  = 1'b0;
        w_own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_g_idx == c_IDX_W'(i)) begin
                w_own_req  = req[i];
                w_own_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Rotating priority search: start one past the last owner and wrap.
    // The inner loop turns the wrapped position into a constant bit
    // select so no variable-width index reaches req.
    // ------------------------------------------------------------------
    always_comb begin : p_rr_select
        int v_pos;
        v_pos       = 0;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_pos = int'(r_last_idx) + k;
            if (v_pos >= NUM_REQ) begin
                v_pos = v_pos - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_sel_found && (v_pos == i) && req[i]) begin
                    w_sel_found = 1'b1;
                    w_sel_idx   = c_IDX_W'(i);
                end
            end
        end
    end

    // A beat is an accepted write. It is suppressed while reset is asserted
    // so that a reset landing mid-burst never pushes a stray word.
    assign w_beat = (r_state == S_GRANT) && w_own_req && !fifo_full && !rst;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin : p_next
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_g_idx_nxt    = r_g_idx;
        w_last_idx_nxt = r_last_idx;
        w_beat_cnt_nxt = r_beat_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_sel_found) begin
                    w_state_nxt    = S_GRANT;
                    w_grant_nxt    = NUM_REQ'(1) << w_sel_idx;
                    w_g_idx_nxt    = w_sel_idx;
                    w_beat_cnt_nxt = '0;
                end
            end

            S_GRANT: begin
                // Withdrawal and burst exhaustion both hand the port back;
                // a full fifo only stalls and never releases.
                if (!w_own_req || (w_beat && (r_beat_cnt == c_LAST_BEAT))) begin
                    w_state_nxt    = S_IDLE;
                    w_grant_nxt    = '0;
                    w_last_idx_nxt = r_g_idx;
                    w_beat_cnt_nxt = '0;
                end else if (w_beat) begin
                    w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin : p_state
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_g_idx    <= '0;
            r_last_idx <= c_IDX_W'(NUM_REQ - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_g_idx    <= w_g_idx_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign grant        = r_grant;
    assign busy         = (r_state == S_GRANT);
    assign fifo_wr      = w_beat;
    assign ack          = w_beat ? r_grant : '0;
    assign fifo_data_in = (r_state == S_GRANT) ? w_own_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Scoreboard bench for fifo_wr_arbiter. Producers are modelled as
//            per-producer data queues that advance on ack; every expected
//            write is queued when stimulus is issued and a monitor compares
//            each fifo write against it. A second instance is built with
//            MAX_BURST=1 for the alternation case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_data_in;
    logic        busy;

    logic [3:0]  req1;
    logic [31:0] req_data1;
    logic [3:0]  ack1;
    logic [3:0]  grant1;
    logic        fifo_full1;
    logic        fifo_wr1;
    logic [7:0]  fifo_data_in1;
    logic        busy1;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .grant(grant), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
        .fifo_data_in(fifo_data_in), .busy(busy)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .req_data(req_data1), .ack(ack1),
        .grant(grant1), .fifo_full(fifo_full1), .fifo_wr(fifo_wr1),
        .fifo_data_in(fifo_data_in1), .busy(busy1)
    );

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] pq[4][$];
    int         errors = 0;
    int         checks = 0;
    int         tn     = 0;

    logic       wr_h[64];
    logic [3:0] gr_h[64];
    logic       busy_h[64];
    logic [7:0] dat_h[64];
    logic       wr1_h[64];
    logic [3:0] ack1_h[64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input int p, input logic [7:0] d);
        exp_t e;
        e.ack  = 4'(1 << p);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req[i] = (pq[i].size() != 0);
            req_data[i*8 +: 8] = (pq[i].size() != 0) ? pq[i][0] : 8'h00;
        end
    endtask

    // One clock: sample mid-cycle, then let producers consume acked words.
    task automatic tick();
        logic [3:0] a;
        @(negedge clk);
        wr_h[tn]   = fifo_wr;
        gr_h[tn]   = grant;
        busy_h[tn] = busy;
        dat_h[tn]  = fifo_data_in;
        wr1_h[tn]  = fifo_wr1;
        ack1_h[tn] = ack1;
        a = ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (a[i] && pq[i].size() != 0) void'(pq[i].pop_front());
        end
        drive();
        if (tn < 63) tn++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) pq[i].delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] wr_pattern(input int len);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < len; i++) p = {p[30:0], wr_h[i]};
        return p;
    endfunction

    // Monitor: invariants every cycle and scoreboard compare on each write.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!($onehot0(grant) && $onehot0(ack) && ((ack != 4'b0) == fifo_wr)
                  && !(fifo_wr && fifo_full))) begin
                errors++;
                $display("FAIL invariant: grant=%b ack=%b wr=%b full=%b", grant, ack, fifo_wr, fifo_full);
            end
            checks++;
            if (!($onehot0(grant1) && $onehot0(ack1) && ((ack1 != 4'b0) == fifo_wr1))) begin
                errors++;
                $display("FAIL invariant1: grant=%b ack=%b wr=%b", grant1, ack1, fifo_wr1);
            end
            if (fifo_wr) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got ack=%b data=%h expected none", ack, fifo_data_in);
                end else begin
                    mon_e = sb.pop_front();
                    if ({ack, fifo_data_in} !== {mon_e.ack, mon_e.data}) begin
                        errors++;
                        $display("FAIL write: got ack=%b data=%h expected ack=%b data=%h",
                                 ack, fifo_data_in, mon_e.ack, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        int done_at;
        rst        = 1'b1;
        req        = '0;
        req_data   = '0;
        fifo_full  = 1'b0;
        req1       = '0;
        req_data1  = {8'h00, 8'h00, 8'hA5, 8'h5A};
        fifo_full1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_ack",   32'(ack),   32'h0);
        chk("rst_wr",    32'(fifo_wr), 32'h0);
        chk("rst_data",  32'(fifo_data_in), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_grant1", 32'(grant1), 32'h0);
        @(posedge clk);
        #1;

        // Single producer, 8 words, two bursts of 4 with one bubble
        tn = 0;
        for (int k = 0; k < 8; k++) begin
            pq[0].push_back(8'(k));
            sb_push(0, 8'(k));
        end
        drive();
        repeat (11) tick();
        chk("s1_wr_pattern", wr_pattern(11), 32'h3DE);
        chk("s1_drained", 32'(pq[0].size()), 32'h0);

        // All four requesting after reset: order 0,1,2,3,0,1,2,3
        do_reset();
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 8; k++) pq[p].push_back(8'(p*16 + k));
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++)
                for (int k = 0; k < 4; k++) sb_push(p, 8'(p*16 + r*4 + k));
        drive();
        tn = 0;
        done_at = -1;
        for (int n = 0; n < 41; n++) begin
            tick();
            if (done_at < 0 && pq[0].size() == 0 && pq[1].size() == 0 &&
                pq[2].size() == 0 && pq[3].size() == 0) done_at = n + 1;
        end
        chk("s2_cycles", 32'(done_at), 32'd40);

        // Fifo full for three cycles in the middle of producer 2's burst
        tn = 0;
        for (int k = 0; k < 6; k++) begin
            pq[2].push_back(8'hA0 + 8'(k));
            sb_push(2, 8'hA0 + 8'(k));
        end
        drive();
        for (int n = 0; n < 12; n++) begin
            fifo_full = (n >= 3 && n <= 5);
            tick();
        end
        fifo_full = 1'b0;
        chk("s3_wr_pattern", wr_pattern(12), 32'h636);
        chk("s3_grant_full_c3", 32'(gr_h[3]), 32'h4);
        chk("s3_grant_full_c5", 32'(gr_h[5]), 32'h4);
        chk("s3_busy_full", 32'(busy_h[4]), 32'h1);
        chk("s3_data_held", 32'(dat_h[4]), 32'hA2);

        // Producer 1 withdraws after two beats while producer 3 waits
        do_reset();
        pq[1].push_back(8'hB0); pq[1].push_back(8'hB1);
        pq[3].push_back(8'hC0); pq[3].push_back(8'hC1);
        sb_push(1, 8'hB0); sb_push(1, 8'hB1);
        sb_push(3, 8'hC0); sb_push(3, 8'hC1);
        drive();
        tn = 0;
        repeat (8) tick();
        chk("s4_wr_pattern", wr_pattern(8), 32'h66);
        chk("s4_grant_withdraw", 32'(gr_h[3]), 32'h2);
        chk("s4_idle_grant", 32'(gr_h[4]), 32'h0);
        chk("s4_idle_busy", 32'(busy_h[4]), 32'h0);
        chk("s4_grant_p3", 32'(gr_h[5]), 32'h8);

        // Reset during producer 2's burst, then req=0101
        tn = 0;
        for (int k = 0; k < 8; k++) pq[2].push_back(8'hD0 + 8'(k));
        sb_push(2, 8'hD0); sb_push(2, 8'hD1);
        sb_push(0, 8'hE0); sb_push(2, 8'hF0);
        drive();
        for (int n = 0; n < 10; n++) begin
            if (n == 3) rst = 1'b1;
            if (n == 4) begin
                rst = 1'b0;
                pq[2].delete();
                pq[0].push_back(8'hE0);
                pq[2].push_back(8'hF0);
                drive();
            end
            tick();
        end
        chk("s5_wr_pattern", wr_pattern(10), 32'h192);
        chk("s5_wr_in_rst", 32'(wr_h[3]), 32'h0);
        chk("s5_grant_after_rst", 32'(gr_h[4]), 32'h0);
        chk("s5_busy_after_rst", 32'(busy_h[4]), 32'h0);
        chk("s5_data_after_rst", 32'(dat_h[4]), 32'h0);
        chk("s5_first_p0", 32'(gr_h[5]), 32'h1);
        chk("s5_then_p2", 32'(gr_h[8]), 32'h4);

        // MAX_BURST=1 instance: strict alternation between producers 0 and 1
        do_reset();
        req1 = 4'b0011;
        tn = 0;
        repeat (8) tick();
        begin
            logic [31:0] p1;
            p1 = '0;
            for (int i = 0; i < 8; i++) p1 = {p1[30:0], wr1_h[i]};
            chk("s6_wr_pattern", p1, 32'h55);
        end
        chk("s6_ack_c1", 32'(ack1_h[1]), 32'h1);
        chk("s6_ack_c3", 32'(ack1_h[3]), 32'h2);
        chk("s6_ack_c5", 32'(ack1_h[5]), 32'h1);
        chk("s6_ack_c7", 32'(ack1_h[7]), 32'h2);
        req1 = 4'b0000;

        repeat (2) tick();
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
